// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Tracks the in-flight destinations, registers the EX operand
// selects and raises a combinational stall. Define FWD_STATS_EN to add the statistics counters.
module fwd_hazard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          ID_Valid,
  input  logic [AW-1:0] ID_Rs,
  input  logic [AW-1:0] ID_Rt,
  input  logic          ID_UseRs,
  input  logic          ID_UseRt,
  input  logic          ID_RegWrite,
  input  logic          ID_MemRead,
  input  logic [AW-1:0] ID_RegDst,
  input  logic          Flush,
  output logic          Stall_Out,
  output logic [FW-1:0] Fwd_A,
  output logic [FW-1:0] Fwd_B
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] Stat_FwdCount,
  output logic [CNT_W-1:0] Stat_StallCount
`endif
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_regwrite;
  logic [DEPTH-1:0] slot_memread;
  logic [AW-1:0]    slot_dst [DEPTH];

  logic [DEPTH-1:0] match_rs;
  logic [DEPTH-1:0] match_rt;
  logic             load_hit;
  logic             hazard;
  logic             capture;
  logic [FW-1:0]    sel_a;
  logic [FW-1:0]    sel_b;
  logic [0:0]       state;

  // Operand matches already fold in the use flags and the register-0 exclusion.
  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_valid[k] && slot_regwrite[k]) begin
        match_rs[k] = ID_UseRs && (ID_Rs != '0) && (slot_dst[k] == ID_Rs);
        match_rt[k] = ID_UseRt && (ID_Rt != '0) && (slot_dst[k] == ID_Rt);
      end
    end
  end

  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (slot_memread[k] && (match_rs[k] || match_rt[k])) begin
        load_hit = 1'b1;
      end
    end
    hazard    = ID_Valid && !Flush && load_hit;
    Stall_Out = hazard;
    capture   = ID_Valid && !Flush && !hazard;
  end

  // Scanning from the oldest slot down lets the youngest producer overwrite the select.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (match_rs[j]) sel_a = FW'(j + 1);
      if (match_rt[j]) sel_b = FW'(j + 1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      slot_valid    <= '0;
      slot_regwrite <= '0;
      slot_memread  <= '0;
      for (int k = 0; k < DEPTH; k++) slot_dst[k] <= '0;
    end else begin
      slot_valid[0]    <= capture;
      slot_regwrite[0] <= capture && ID_RegWrite;
      slot_memread[0]  <= capture && ID_MemRead;
      slot_dst[0]      <= capture ? ID_RegDst : '0;
      for (int k = 1; k < DEPTH; k++) begin
        slot_valid[k]    <= slot_valid[k-1];
        slot_regwrite[k] <= slot_regwrite[k-1];
        slot_memread[k]  <= slot_memread[k-1];
        slot_dst[k]      <= slot_dst[k-1];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Fwd_A <= '0;
      Fwd_B <= '0;
    end else begin
      Fwd_A <= capture ? sel_a : '0;
      Fwd_B <= capture ? sel_b : '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= hazard ? STALL : RUN;
        STALL:   state <= (hazard && !Flush) ? STALL : RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FWD_STATS_EN
  logic [1:0]     fwd_inc;
  logic [CNT_W:0] fwd_sum;
  logic [CNT_W:0] stall_sum;

  // The extra top bit of each sum flags overflow so the counters stick at all-ones.
  always_comb begin
    fwd_inc   = {1'b0, capture && (sel_a != '0)} + {1'b0, capture && (sel_b != '0)};
    fwd_sum   = {1'b0, Stat_FwdCount} + (CNT_W + 1)'(fwd_inc);
    stall_sum = {1'b0, Stat_StallCount} + (CNT_W + 1)'(state == STALL);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Stat_FwdCount   <= '0;
      Stat_StallCount <= '0;
    end else begin
      Stat_FwdCount   <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
      Stat_StallCount <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance plus a DEPTH=3/LOAD_LAT=2 instance, driven from
// hand-derived vector tables with a queue of expected forward selects.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       regwrite;
    logic       memread;
    logic [4:0] dst;
    logic       flush;
    logic       exp_stall;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  logic Clk;
  logic Rst_n;
  vec_t drv0;
  vec_t drv1;
  logic       stall0, stall1;
  logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
`ifdef FWD_STATS_EN
  logic [15:0] fcnt0, scnt0, fcnt1, scnt1;
`endif

  int checks;
  int failures;
  logic [3:0] sb [$];
  vec_t tab0 [24];
  vec_t tab1 [8];

  fwd_hazard_unit dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(drv0.valid), .ID_Rs(drv0.rs), .ID_Rt(drv0.rt),
    .ID_UseRs(drv0.use_rs), .ID_UseRt(drv0.use_rt), .ID_RegWrite(drv0.regwrite),
    .ID_MemRead(drv0.memread), .ID_RegDst(drv0.dst), .Flush(drv0.flush),
    .Stall_Out(stall0), .Fwd_A(fwd_a0), .Fwd_B(fwd_b0)
`ifdef FWD_STATS_EN
    , .Stat_FwdCount(fcnt0), .Stat_StallCount(scnt0)
`endif
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(drv1.valid), .ID_Rs(drv1.rs), .ID_Rt(drv1.rt),
    .ID_UseRs(drv1.use_rs), .ID_UseRt(drv1.use_rt), .ID_RegWrite(drv1.regwrite),
    .ID_MemRead(drv1.memread), .ID_RegDst(drv1.dst), .Flush(drv1.flush),
    .Stall_Out(stall1), .Fwd_A(fwd_a1), .Fwd_B(fwd_b1)
`ifdef FWD_STATS_EN
    , .Stat_FwdCount(fcnt1), .Stat_StallCount(scnt1)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic v, input int rs, input int rt, input logic ur,
                              input logic ut, input logic rw, input logic mr, input int dst,
                              input logic fl, input logic es, input int ea, input int eb);
    vec_t r;
    r.valid = v;      r.rs = 5'(rs);     r.rt = 5'(rt);
    r.use_rs = ur;    r.use_rt = ut;     r.regwrite = rw;
    r.memread = mr;   r.dst = 5'(dst);   r.flush = fl;
    r.exp_stall = es; r.exp_a = 2'(ea);  r.exp_b = 2'(eb);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int unit);
    drv0 = (unit == 0) ? v : '0;
    drv1 = (unit == 1) ? v : '0;
  endtask

  // One ID cycle: stall is checked before the edge, the queued select after it.
  task automatic runVector(input vec_t v, input int unit, input string tag);
    logic [3:0] e;
    applyStimulus(v, unit);
    #1;
    checkOutput({tag, " stall"}, (unit == 0) ? 16'(stall0) : 16'(stall1), 16'(v.exp_stall));
    sb.push_back({v.exp_a, v.exp_b});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    checkOutput({tag, " fwd_a"}, (unit == 0) ? 16'(fwd_a0) : 16'(fwd_a1), 16'(e[3:2]));
    checkOutput({tag, " fwd_b"}, (unit == 0) ? 16'(fwd_b0) : 16'(fwd_b1), 16'(e[1:0]));
    @(negedge Clk);
  endtask

  initial begin
    logic [3:0] e;
    checks = 0;
    failures = 0;

    //             v  rs rt ur ut rw mr dst fl st  A  B
    tab0[0]  = mk(1,  1, 2, 1, 1, 1, 0,  3, 0, 0, 0, 0);
    tab0[1]  = mk(1,  3, 5, 1, 1, 1, 0,  4, 0, 0, 1, 0);
    tab0[2]  = mk(0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tab0[3]  = mk(0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tab0[4]  = mk(1,  1, 1, 1, 1, 1, 0,  3, 0, 0, 0, 0);
    tab0[5]  = mk(1,  1, 1, 1, 1, 1, 0,  3, 0, 0, 0, 0);
    tab0[6]  = mk(1,  3, 0, 1, 1, 1, 0,  8, 0, 0, 1, 0);
    tab0[7]  = mk(1,  1, 1, 1, 1, 1, 0,  3, 0, 0, 0, 0);
    tab0[8]  = mk(1,  1, 2, 1, 1, 1, 0,  5, 0, 0, 0, 0);
    tab0[9]  = mk(1,  3, 5, 1, 1, 1, 0,  6, 0, 0, 2, 1);
    tab0[10] = mk(1,  1, 2, 1, 0, 1, 1,  2, 0, 0, 0, 0);
    tab0[11] = mk(1,  2, 2, 1, 1, 1, 0,  7, 0, 1, 0, 0);
    tab0[12] = mk(1,  2, 2, 1, 1, 1, 0,  7, 0, 0, 2, 2);
    tab0[13] = mk(1,  1, 1, 1, 1, 1, 0,  0, 0, 0, 0, 0);
    tab0[14] = mk(1,  0, 0, 1, 1, 1, 0,  9, 0, 0, 0, 0);
    tab0[15] = mk(1,  1, 9, 1, 0, 1, 0, 10, 0, 0, 0, 0);
    tab0[16] = mk(1,  1, 0, 1, 0, 1, 1, 11, 0, 0, 0, 0);
    tab0[17] = mk(1, 11,11, 1, 1, 1, 0, 12, 1, 0, 0, 0);
    tab0[18] = mk(1, 11,10, 1, 1, 1, 0, 13, 0, 0, 2, 0);
    tab0[19] = mk(1,  1, 0, 1, 0, 1, 1, 14, 0, 0, 0, 0);
    tab0[20] = mk(0, 14, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    tab0[21] = mk(1,  1, 0, 1, 0, 1, 1, 15, 0, 0, 0, 0);
    tab0[22] = mk(1,  1,15, 1, 1, 1, 0, 16, 0, 1, 0, 0);
    tab0[23] = mk(1,  1,15, 1, 1, 1, 0, 16, 0, 0, 0, 2);

    tab1[0]  = mk(1,  1, 0, 1, 0, 1, 1,  2, 0, 0, 0, 0);
    tab1[1]  = mk(1,  1, 1, 1, 1, 1, 0,  4, 0, 0, 0, 0);
    tab1[2]  = mk(1,  2, 2, 1, 1, 1, 0,  7, 0, 1, 0, 0);
    tab1[3]  = mk(1,  2, 2, 1, 1, 1, 0,  7, 0, 0, 3, 3);
    tab1[4]  = mk(1,  1, 0, 1, 0, 1, 1,  5, 0, 0, 0, 0);
    tab1[5]  = mk(1,  5, 1, 1, 1, 1, 0,  8, 0, 1, 0, 0);
    tab1[6]  = mk(1,  5, 1, 1, 1, 1, 0,  8, 0, 1, 0, 0);
    tab1[7]  = mk(1,  5, 1, 1, 1, 1, 0,  8, 0, 0, 3, 0);

    Rst_n = 1'b0;
    applyStimulus('0, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset stall", 16'(stall0), 16'd0);
    checkOutput("reset fwd_a", 16'(fwd_a0), 16'd0);
    checkOutput("reset fwd_b", 16'(fwd_b0), 16'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 24; i++) runVector(tab0[i], 0, $sformatf("u0 row%0d", i));
`ifdef FWD_STATS_EN
    checkOutput("u0 fwd count", fcnt0, 16'd8);
    checkOutput("u0 stall count", scnt0, 16'd2);
`endif

    // Reset asserted while a load-use stall is being raised and a nonzero select is live.
    runVector(mk(1, 1, 1, 1, 1, 1, 0, 20, 0, 0, 0, 0), 0, "u0 pre-reset add");
    runVector(mk(1, 20, 0, 1, 0, 1, 1, 21, 0, 0, 1, 0), 0, "u0 pre-reset lw");
    applyStimulus(mk(1, 21, 1, 1, 1, 1, 0, 22, 0, 1, 0, 0), 0);
    #1;
    checkOutput("u0 stall before reset", 16'(stall0), 16'd1);
    checkOutput("u0 fwd_a before reset", 16'(fwd_a0), 16'd1);
`ifdef FWD_STATS_EN
    checkOutput("u0 fwd count before reset", fcnt0, 16'd9);
`endif
    Rst_n = 1'b0;
    #1;
    checkOutput("mid reset stall", 16'(stall0), 16'd0);
    checkOutput("mid reset fwd_a", 16'(fwd_a0), 16'd0);
    checkOutput("mid reset fwd_b", 16'(fwd_b0), 16'd0);
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checkOutput("post reset stall", 16'(stall0), 16'd0);
    sb.push_back(4'b0000);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    checkOutput("post reset fwd_a", 16'(fwd_a0), 16'(e[3:2]));
    checkOutput("post reset fwd_b", 16'(fwd_b0), 16'(e[1:0]));
`ifdef FWD_STATS_EN
    checkOutput("post reset fwd count", fcnt0, 16'd0);
    checkOutput("post reset stall count", scnt0, 16'd0);
`endif
    @(negedge Clk);

    for (int i = 0; i < 8; i++) runVector(tab1[i], 1, $sformatf("u1 row%0d", i));
`ifdef FWD_STATS_EN
    checkOutput("u1 fwd count", fcnt1, 16'd3);
    checkOutput("u1 stall count", scnt1, 16'd3);
`endif

    applyStimulus('0, 0);
    repeat (2) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
